// File: rtl/axi4_pkg.sv
// Shared AXI4 constants, FSM state type and response-ranking helper for the
// axi4_burst_master block.
package axi4_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // 8-byte beats on a 64-bit data bus
  localparam logic [2:0] AXI_SIZE_64 = 3'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AW   = 3'd1,
    W    = 3'd2,
    B    = 3'd3,
    AR   = 3'd4,
    R    = 3'd5
  } axi_state_e;

  // Worse of two responses: DECERR > SLVERR > EXOKAY > OKAY
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] res;
    if (a == AXI_RESP_DECERR || b == AXI_RESP_DECERR) begin
      res = AXI_RESP_DECERR;
    end else if (a == AXI_RESP_SLVERR || b == AXI_RESP_SLVERR) begin
      res = AXI_RESP_SLVERR;
    end else if (a == AXI_RESP_EXOKAY || b == AXI_RESP_EXOKAY) begin
      res = AXI_RESP_EXOKAY;
    end else begin
      res = AXI_RESP_OKAY;
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4_beat_ctr.sv
// Beat counter for one AXI burst: cleared when a command is accepted,
// advanced on each data handshake; is_last flags the beat numbered len.
module axi4_beat_ctr (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  input  logic [7:0] len,
  output logic       is_last
);

  logic [7:0] cnt_r;

  // Track how many beats of the current burst have been exchanged
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= 8'd0;
    end else if (clear) begin
      cnt_r <= 8'd0;
    end else if (inc) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign is_last = (cnt_r == len);

endmodule

// File: rtl/axi4_burst_master_chk.sv
// Simulation checker for axi4_burst_master: a burst must stay inside one
// 4 KiB page. Contains no synthesizable logic of consequence.
module axi4_burst_master_chk (
  input logic        clock,
  input logic        reset,
  input logic        cmd_fire,
  input logic [11:0] page_off,
  input logic [7:0]  cmd_len
);

  logic [13:0] last_byte_s;

  // Offset of the final byte touched by the burst within its page
  assign last_byte_s = {2'b00, page_off | 12'h007} + {3'b000, cmd_len, 3'b000};

  // Accepted command must not run past the end of its 4 KiB page
  a_no_4k_cross: assert property (@(posedge clock) disable iff (reset)
    cmd_fire |-> (last_byte_s <= 14'd4095))
    else $error("axi4_burst_master: burst crosses a 4 KiB boundary");

endmodule

// File: rtl/axi4_burst_master.sv
// AXI4 initiator: turns a command + data-stream interface into single-ID INCR
// bursts, one transaction outstanding at a time.
// Optional feature: define AXI4_RESP_CHECK_EN to get a sticky err flag on
// non-OKAY responses and on r_last / beat-count disagreement.
module axi4_burst_master
  import axi4_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 28,
  parameter int DATA_W = 64,
  parameter int TXN_ID = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic                wdata_valid,
  output logic                wdata_ready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                rdata_valid,
  input  logic                rdata_ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                rdata_last,
  output logic                done,
  output logic [1:0]          done_resp,
  output logic                err,
  output logic                io_axi4_0_aw_valid,
  input  logic                io_axi4_0_aw_ready,
  output logic [ID_W-1:0]     io_axi4_0_aw_id,
  output logic [ADDR_W-1:0]   io_axi4_0_aw_addr,
  output logic [7:0]          io_axi4_0_aw_len,
  output logic [2:0]          io_axi4_0_aw_size,
  output logic [1:0]          io_axi4_0_aw_burst,
  output logic                io_axi4_0_w_valid,
  input  logic                io_axi4_0_w_ready,
  output logic [DATA_W-1:0]   io_axi4_0_w_data,
  output logic [DATA_W/8-1:0] io_axi4_0_w_strb,
  output logic                io_axi4_0_w_last,
  input  logic                io_axi4_0_b_valid,
  output logic                io_axi4_0_b_ready,
  input  logic [1:0]          io_axi4_0_b_resp,
  output logic                io_axi4_0_ar_valid,
  input  logic                io_axi4_0_ar_ready,
  output logic [ID_W-1:0]     io_axi4_0_ar_id,
  output logic [ADDR_W-1:0]   io_axi4_0_ar_addr,
  output logic [7:0]          io_axi4_0_ar_len,
  output logic [2:0]          io_axi4_0_ar_size,
  output logic [1:0]          io_axi4_0_ar_burst,
  input  logic                io_axi4_0_r_valid,
  output logic                io_axi4_0_r_ready,
  input  logic [DATA_W-1:0]   io_axi4_0_r_data,
  input  logic [1:0]          io_axi4_0_r_resp,
  input  logic                io_axi4_0_r_last
);

  localparam logic [ID_W-1:0] TXN_ID_C = ID_W'(TXN_ID);

  axi_state_e        state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        len_r;
  logic              cmd_ready_r;
  logic              aw_valid_r;
  logic              ar_valid_r;
  logic              b_ready_r;
  logic              done_r;
  logic [1:0]        done_resp_r;
  logic [1:0]        resp_max_r;
  logic              is_last_s;
  logic              cmd_fire_s;
  logic              w_fire_s;
  logic              b_fire_s;
  logic              r_fire_s;
  logic              in_w_s;
  logic              in_r_s;

  assign in_w_s     = (state_r == W);
  assign in_r_s     = (state_r == R);
  assign cmd_fire_s = cmd_valid & cmd_ready_r;
  assign w_fire_s   = in_w_s & wdata_valid & io_axi4_0_w_ready;
  assign b_fire_s   = (state_r == B) & io_axi4_0_b_valid & b_ready_r;
  assign r_fire_s   = in_r_s & io_axi4_0_r_valid & rdata_ready;

  axi4_beat_ctr u_beat_ctr (
    .clock   (clock),
    .reset   (reset),
    .clear   (cmd_fire_s),
    .inc     (w_fire_s | r_fire_s),
    .len     (len_r),
    .is_last (is_last_s)
  );

  axi4_burst_master_chk u_chk (
    .clock    (clock),
    .reset    (reset),
    .cmd_fire (cmd_fire_s),
    .page_off (cmd_addr[11:0]),
    .cmd_len  (cmd_len)
  );

  // Transaction sequencer with registered control outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      len_r       <= 8'd0;
      cmd_ready_r <= 1'b1;
      aw_valid_r  <= 1'b0;
      ar_valid_r  <= 1'b0;
      b_ready_r   <= 1'b0;
      done_r      <= 1'b0;
      done_resp_r <= 2'b00;
      resp_max_r  <= 2'b00;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_fire_s) begin
            addr_r      <= {cmd_addr[ADDR_W-1:3], 3'b000};
            len_r       <= cmd_len;
            cmd_ready_r <= 1'b0;
            resp_max_r  <= AXI_RESP_OKAY;
            if (cmd_write) begin
              state_r    <= AW;
              aw_valid_r <= 1'b1;
            end else begin
              state_r    <= AR;
              ar_valid_r <= 1'b1;
            end
          end
        end
        AW: begin
          if (io_axi4_0_aw_ready) begin
            aw_valid_r <= 1'b0;
            state_r    <= W;
          end
        end
        W: begin
          if (w_fire_s && is_last_s) begin
            b_ready_r <= 1'b1;
            state_r   <= B;
          end
        end
        B: begin
          if (b_fire_s) begin
            b_ready_r   <= 1'b0;
            done_r      <= 1'b1;
            done_resp_r <= io_axi4_0_b_resp;
            cmd_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        AR: begin
          if (io_axi4_0_ar_ready) begin
            ar_valid_r <= 1'b0;
            state_r    <= R;
          end
        end
        R: begin
          if (r_fire_s) begin
            resp_max_r <= resp_worst(resp_max_r, io_axi4_0_r_resp);
            if (io_axi4_0_r_last) begin
              done_r      <= 1'b1;
              done_resp_r <= resp_worst(resp_max_r, io_axi4_0_r_resp);
              cmd_ready_r <= 1'b1;
              state_r     <= IDLE;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          cmd_ready_r <= 1'b1;
          aw_valid_r  <= 1'b0;
          ar_valid_r  <= 1'b0;
          b_ready_r   <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXI4_RESP_CHECK_EN
  logic err_r;

  // Latch any bad response or r_last / beat-count disagreement until reset
  always_ff @(posedge clock) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (b_fire_s && (io_axi4_0_b_resp != AXI_RESP_OKAY)) begin
      err_r <= 1'b1;
    end else if (r_fire_s && ((io_axi4_0_r_resp != AXI_RESP_OKAY) ||
                              (io_axi4_0_r_last != is_last_s))) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready = cmd_ready_r;
  assign done      = done_r;
  assign done_resp = done_resp_r;

  assign io_axi4_0_aw_valid = aw_valid_r;
  assign io_axi4_0_aw_id    = TXN_ID_C;
  assign io_axi4_0_aw_addr  = addr_r;
  assign io_axi4_0_aw_len   = len_r;
  assign io_axi4_0_aw_size  = AXI_SIZE_64;
  assign io_axi4_0_aw_burst = AXI_BURST_INCR;

  // Write data passes straight through, but only once AW has been accepted
  assign io_axi4_0_w_valid = in_w_s & wdata_valid;
  assign io_axi4_0_w_data  = wdata;
  assign io_axi4_0_w_strb  = wstrb;
  assign io_axi4_0_w_last  = in_w_s & is_last_s;
  assign wdata_ready       = in_w_s & io_axi4_0_w_ready;

  assign io_axi4_0_b_ready = b_ready_r;

  assign io_axi4_0_ar_valid = ar_valid_r;
  assign io_axi4_0_ar_id    = TXN_ID_C;
  assign io_axi4_0_ar_addr  = addr_r;
  assign io_axi4_0_ar_len   = len_r;
  assign io_axi4_0_ar_size  = AXI_SIZE_64;
  assign io_axi4_0_ar_burst = AXI_BURST_INCR;

  // Read data stream mirrors the R channel while a read burst is active
  assign rdata_valid       = in_r_s & io_axi4_0_r_valid;
  assign rdata             = io_axi4_0_r_data;
  assign rdata_last        = in_r_s & io_axi4_0_r_last;
  assign io_axi4_0_r_ready = in_r_s & rdata_ready;

endmodule
